id_ex_stage: RTL and testbench

- ID/EX pipeline boundary of the 16-bit CPU; sits directly downstream of the decode-stage immediate extender.
- Captures the sign/zero-extended immediate, register operands, register addresses and control bits from decode; presents them registered to the EX stage.
- Provides valid/ready flow control, EX-requested stall, branch flush, and load-use hazard detection with one-cycle bubble insertion.
- Keeps a saturating count of inserted bubbles for performance debug.

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/id_ex_stage_if.sv | 60 ++++++
 rtl/id_ex_stage_load_use_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - ID/EX stage widths, NOP encodings and register-address map.
package id_ex_stage_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_REG_AW   = 4;
   localparam int DEF_ALU_OP_W = 4;
   localparam int DEF_CNT_W    = 16;

   typedef enum logic [DEF_ALU_OP_W-1:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_XOR = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRA = 4'd7
   } alu_op_e;

   localparam logic [DEF_ALU_OP_W-1:0] ALU_OP_NOP = ALU_NOP;

   // Special registers share the address space above the eight general registers.
   localparam logic [DEF_REG_AW-1:0] REG_SP = 4'd8;
   localparam logic [DEF_REG_AW-1:0] REG_T  = 4'd9;
   localparam logic [DEF_REG_AW-1:0] REG_IH = 4'd10;
   localparam logic [DEF_REG_AW-1:0] REG_RA = 4'd11;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side and EX-side bus of the ID/EX pipeline boundary.
interface id_ex_stage_if
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int REG_AW   = DEF_REG_AW,
   parameter int ALU_OP_W = DEF_ALU_OP_W,
   parameter int CNT_W    = DEF_CNT_W
) ();

   logic                id_valid;
   logic                id_ready;
   logic [DATA_W-1:0]   imm_in;
   logic [DATA_W-1:0]   rx_data;
   logic [DATA_W-1:0]   ry_data;
   logic [REG_AW-1:0]   rx_addr;
   logic [REG_AW-1:0]   ry_addr;
   logic                use_rx;
   logic                use_ry;
   logic [REG_AW-1:0]   rd_addr;
   logic [DATA_W-1:0]   pc_in;
   logic [ALU_OP_W-1:0] alu_op_in;
   logic                alu_src_imm_in;
   logic                mem_read_in;
   logic                mem_write_in;
   logic                reg_write_in;
   logic                flush;
   logic                ex_ready;
   logic                ex_valid;
   logic [DATA_W-1:0]   ex_imm;
   logic [DATA_W-1:0]   ex_rx_data;
   logic [DATA_W-1:0]   ex_ry_data;
   logic [DATA_W-1:0]   ex_pc;
   logic [REG_AW-1:0]   ex_rd_addr;
   logic [ALU_OP_W-1:0] ex_alu_op;
   logic                ex_alu_src_imm;
   logic                ex_mem_read;
   logic                ex_mem_write;
   logic                ex_reg_write;
   logic [CNT_W-1:0]    bubble_cnt;

   modport master (
      output id_valid, imm_in, rx_data, ry_data, rx_addr, ry_addr, use_rx, use_ry,
             rd_addr, pc_in, alu_op_in, alu_src_imm_in, mem_read_in, mem_write_in,
             reg_write_in, flush, ex_ready,
      input  id_ready, ex_valid, ex_imm, ex_rx_data, ex_ry_data, ex_pc, ex_rd_addr,
             ex_alu_op, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write,
             bubble_cnt
   );

   modport slave (
      input  id_valid, imm_in, rx_data, ry_data, rx_addr, ry_addr, use_rx, use_ry,
             rd_addr, pc_in, alu_op_in, alu_src_imm_in, mem_read_in, mem_write_in,
             reg_write_in, flush, ex_ready,
      output id_ready, ex_valid, ex_imm, ex_rx_data, ex_ry_data, ex_pc, ex_rd_addr,
             ex_alu_op, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write,
             bubble_cnt
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard compare.
module load_use_detect
   import id_ex_stage_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              id_valid,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic              use_rx,
   input  logic [REG_AW-1:0] rx_addr,
   input  logic              use_ry,
   input  logic [REG_AW-1:0] ry_addr,
   output logic              hazard
);

   logic ex_is_load;
   logic src_match;

   assign ex_is_load = ex_valid & ex_mem_read & ex_reg_write;
   assign src_match  = (use_rx & (rx_addr == ex_rd_addr)) |
                       (use_ry & (ry_addr == ex_rd_addr));
   assign hazard     = id_valid & ex_is_load & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with flow control, flush and load-use bubbles.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int REG_AW   = DEF_REG_AW,
   parameter int ALU_OP_W = DEF_ALU_OP_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   id_ex_stage_if.slave  bus
);

   logic                ex_valid_r;
   logic [DATA_W-1:0]   ex_imm_r;
   logic [DATA_W-1:0]   ex_rx_data_r;
   logic [DATA_W-1:0]   ex_ry_data_r;
   logic [DATA_W-1:0]   ex_pc_r;
   logic [REG_AW-1:0]   ex_rd_addr_r;
   logic [ALU_OP_W-1:0] ex_alu_op_r;
   logic                ex_alu_src_imm_r;
   logic                ex_mem_read_r;
   logic                ex_mem_write_r;
   logic                ex_reg_write_r;
   logic [CNT_W-1:0]    bubble_cnt_r;

   logic hazard;
   logic stall;
   logic accept;
   logic clear;
   logic count_en;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .id_valid     (bus.id_valid),
      .ex_valid     (ex_valid_r),
      .ex_mem_read  (ex_mem_read_r),
      .ex_reg_write (ex_reg_write_r),
      .ex_rd_addr   (ex_rd_addr_r),
      .use_rx       (bus.use_rx),
      .rx_addr      (bus.rx_addr),
      .use_ry       (bus.use_ry),
      .ry_addr      (bus.ry_addr),
      .hazard       (hazard)
   );

   assign stall       = ex_valid_r & ~bus.ex_ready;
   assign bus.id_ready = ~bus.flush & ~hazard & (~ex_valid_r | bus.ex_ready);
   assign accept      = bus.id_valid & bus.id_ready;
   // Everything that is neither a hold nor an accept loads the all-zero NOP.
   assign clear       = bus.flush | (~stall & ~accept);
   assign count_en    = ~bus.flush & ~stall & hazard;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ex_valid_r       <= 1'b0;
         ex_imm_r         <= '0;
         ex_rx_data_r     <= '0;
         ex_ry_data_r     <= '0;
         ex_pc_r          <= '0;
         ex_rd_addr_r     <= '0;
         ex_alu_op_r      <= ALU_OP_W'(ALU_OP_NOP);
         ex_alu_src_imm_r <= 1'b0;
         ex_mem_read_r    <= 1'b0;
         ex_mem_write_r   <= 1'b0;
         ex_reg_write_r   <= 1'b0;
      end else if (accept) begin
         ex_valid_r       <= 1'b1;
         ex_imm_r         <= bus.imm_in;
         ex_rx_data_r     <= bus.rx_data;
         ex_ry_data_r     <= bus.ry_data;
         ex_pc_r          <= bus.pc_in;
         ex_rd_addr_r     <= bus.rd_addr;
         ex_alu_op_r      <= bus.alu_op_in;
         ex_alu_src_imm_r <= bus.alu_src_imm_in;
         ex_mem_read_r    <= bus.mem_read_in;
         ex_mem_write_r   <= bus.mem_write_in;
         ex_reg_write_r   <= bus.reg_write_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_r <= '0;
      end else if (count_en && (bubble_cnt_r != {CNT_W{1'b1}})) begin
         bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
      end
   end

   assign bus.ex_valid       = ex_valid_r;
   assign bus.ex_imm         = ex_imm_r;
   assign bus.ex_rx_data     = ex_rx_data_r;
   assign bus.ex_ry_data     = ex_ry_data_r;
   assign bus.ex_pc          = ex_pc_r;
   assign bus.ex_rd_addr     = ex_rd_addr_r;
   assign bus.ex_alu_op      = ex_alu_op_r;
   assign bus.ex_alu_src_imm = ex_alu_src_imm_r;
   assign bus.ex_mem_read    = ex_mem_read_r;
   assign bus.ex_mem_write   = ex_mem_write_r;
   assign bus.ex_reg_write   = ex_reg_write_r;
   assign bus.bubble_cnt     = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

   localparam int CNT_W = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   id_ex_stage_if #(.CNT_W(CNT_W)) bus ();

   id_ex_stage #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      bus.id_valid       = 1'b0;
      bus.imm_in         = '0;
      bus.rx_data        = '0;
      bus.ry_data        = '0;
      bus.rx_addr        = '0;
      bus.ry_addr        = '0;
      bus.use_rx         = 1'b0;
      bus.use_ry         = 1'b0;
      bus.rd_addr        = '0;
      bus.pc_in          = '0;
      bus.alu_op_in      = '0;
      bus.alu_src_imm_in = 1'b0;
      bus.mem_read_in    = 1'b0;
      bus.mem_write_in   = 1'b0;
      bus.reg_write_in   = 1'b0;
      bus.flush          = 1'b0;
      bus.ex_ready       = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus.ex_valid); end
      n_cmp++; if (bus.ex_imm !== 16'h0 || bus.ex_rx_data !== 16'h0 || bus.ex_pc !== 16'h0) begin n_err++; $display("FAIL reset_data got imm=%h rx=%h pc=%h want 0", bus.ex_imm, bus.ex_rx_data, bus.ex_pc); end
      n_cmp++; if ({bus.ex_alu_op, bus.ex_mem_read, bus.ex_reg_write, bus.ex_mem_write, bus.ex_alu_src_imm} !== 8'h0) begin n_err++; $display("FAIL reset_ctrl got op=%h mr=%b rw=%b want 0", bus.ex_alu_op, bus.ex_mem_read, bus.ex_reg_write); end
      n_cmp++; if (bus.bubble_cnt !== 8'h00) begin n_err++; $display("FAIL reset_cnt got %h want 00", bus.bubble_cnt); end
      n_cmp++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.id_ready); end
   endtask

   task automatic test_single();
      bus.imm_in       = 16'hFFF0;
      bus.rx_data      = 16'h1234;
      bus.ry_data      = 16'hBEEF;
      bus.pc_in        = 16'h0100;
      bus.rd_addr      = 4'd3;
      bus.alu_op_in    = 4'd1;
      bus.reg_write_in = 1'b1;
      bus.id_valid     = 1'b1;
      #1;
      n_cmp++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", bus.id_ready); end
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL single_no_comb got %b want 0", bus.ex_valid); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bus.ex_valid); end
      n_cmp++; if (bus.ex_imm !== 16'hFFF0 || bus.ex_rx_data !== 16'h1234 || bus.ex_ry_data !== 16'hBEEF) begin n_err++; $display("FAIL single_data got imm=%h rx=%h ry=%h want fff0 1234 beef", bus.ex_imm, bus.ex_rx_data, bus.ex_ry_data); end
      n_cmp++; if (bus.ex_rd_addr !== 4'd3 || bus.ex_reg_write !== 1'b1 || bus.ex_alu_op !== 4'd1 || bus.ex_pc !== 16'h0100) begin n_err++; $display("FAIL single_ctrl got rd=%0d rw=%b op=%0d pc=%h want 3 1 1 0100", bus.ex_rd_addr, bus.ex_reg_write, bus.ex_alu_op, bus.ex_pc); end
      set_idle();
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_imm !== 16'h0 || bus.ex_reg_write !== 1'b0 || bus.ex_alu_op !== 4'd0) begin n_err++; $display("FAIL drain got v=%b imm=%h rw=%b op=%0d want 0", bus.ex_valid, bus.ex_imm, bus.ex_reg_write, bus.ex_alu_op); end
   endtask

   task automatic test_stall();
      bus.imm_in   = 16'h1111;
      bus.rd_addr  = 4'd5;
      bus.id_valid = 1'b1;
      tick();
      bus.ex_ready = 1'b0;
      bus.imm_in   = 16'h2222;
      bus.rd_addr  = 4'd6;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d] got %b want 0", i, bus.id_ready); end
         tick();
         n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 16'h1111 || bus.ex_rd_addr !== 4'd5) begin n_err++; $display("FAIL stall_hold[%0d] got v=%b imm=%h rd=%0d want 1 1111 5", i, bus.ex_valid, bus.ex_imm, bus.ex_rd_addr); end
      end
      bus.ex_ready = 1'b1;
      #1;
      n_cmp++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b want 1", bus.id_ready); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 16'h2222 || bus.ex_rd_addr !== 4'd6) begin n_err++; $display("FAIL stall_release got v=%b imm=%h rd=%0d want 1 2222 6", bus.ex_valid, bus.ex_imm, bus.ex_rd_addr); end
      set_idle();
      tick();
   endtask

   task automatic test_no_hazard();
      bus.mem_read_in  = 1'b1;
      bus.reg_write_in = 1'b1;
      bus.rd_addr      = 4'd2;
      bus.id_valid     = 1'b1;
      tick();
      bus.mem_read_in  = 1'b0;
      bus.rd_addr      = 4'd4;
      bus.imm_in       = 16'h0042;
      bus.use_rx       = 1'b0;
      bus.rx_addr      = 4'd2;
      bus.use_ry       = 1'b1;
      bus.ry_addr      = 4'd7;
      #1;
      n_cmp++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL nohaz_ready got %b want 1", bus.id_ready); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 16'h0042 || bus.ex_rd_addr !== 4'd4) begin n_err++; $display("FAIL nohaz_next got v=%b imm=%h rd=%0d want 1 0042 4", bus.ex_valid, bus.ex_imm, bus.ex_rd_addr); end
      n_cmp++; if (bus.bubble_cnt !== 8'h00) begin n_err++; $display("FAIL nohaz_cnt got %h want 00", bus.bubble_cnt); end
      set_idle();
      tick();
   endtask

   task automatic test_load_use();
      bus.mem_read_in  = 1'b1;
      bus.reg_write_in = 1'b1;
      bus.rd_addr      = 4'd2;
      bus.id_valid     = 1'b1;
      tick();
      bus.mem_read_in  = 1'b0;
      bus.rd_addr      = 4'd4;
      bus.imm_in       = 16'h0042;
      bus.use_rx       = 1'b1;
      bus.rx_addr      = 4'd2;
      #1;
      n_cmp++; if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL lu_ready_hazard got %b want 0", bus.id_ready); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_reg_write !== 1'b0) begin n_err++; $display("FAIL lu_bubble got v=%b mr=%b rw=%b want 0 0 0", bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write); end
      n_cmp++; if (bus.bubble_cnt !== 8'h01) begin n_err++; $display("FAIL lu_cnt got %h want 01", bus.bubble_cnt); end
      n_cmp++; if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL lu_ready_after got %b want 1", bus.id_ready); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 16'h0042 || bus.ex_rd_addr !== 4'd4) begin n_err++; $display("FAIL lu_dependent got v=%b imm=%h rd=%0d want 1 0042 4", bus.ex_valid, bus.ex_imm, bus.ex_rd_addr); end
      n_cmp++; if (bus.bubble_cnt !== 8'h01) begin n_err++; $display("FAIL lu_single_bubble got %h want 01", bus.bubble_cnt); end
      set_idle();
      tick();
   endtask

   task automatic test_flush();
      bus.imm_in       = 16'h5555;
      bus.mem_read_in  = 1'b1;
      bus.reg_write_in = 1'b1;
      bus.rd_addr      = 4'd2;
      bus.id_valid     = 1'b1;
      tick();
      bus.ex_ready = 1'b0;
      bus.flush    = 1'b1;
      bus.imm_in   = 16'h6666;
      bus.use_rx   = 1'b1;
      bus.rx_addr  = 4'd2;
      #1;
      n_cmp++; if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", bus.id_ready); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_imm !== 16'h0 || bus.ex_mem_read !== 1'b0 || bus.ex_reg_write !== 1'b0) begin n_err++; $display("FAIL flush_kill got v=%b imm=%h mr=%b rw=%b want 0", bus.ex_valid, bus.ex_imm, bus.ex_mem_read, bus.ex_reg_write); end
      n_cmp++; if (bus.bubble_cnt !== 8'h01) begin n_err++; $display("FAIL flush_cnt got %h want 01", bus.bubble_cnt); end
      set_idle();
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_not_taken got %b want 0", bus.ex_valid); end
   endtask

   task automatic test_saturation();
      bus.mem_read_in  = 1'b1;
      bus.reg_write_in = 1'b1;
      bus.rd_addr      = 4'd2;
      bus.use_rx       = 1'b1;
      bus.rx_addr      = 4'd2;
      bus.id_valid     = 1'b1;
      // Self-dependent loads alternate accept / bubble, one bubble per two cycles.
      for (int i = 0; i < 2 * 253; i++) tick();
      n_cmp++; if (bus.bubble_cnt !== 8'hFE) begin n_err++; $display("FAIL sat_pre got %h want fe", bus.bubble_cnt); end
      tick();
      tick();
      n_cmp++; if (bus.bubble_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_full got %h want ff", bus.bubble_cnt); end
      tick();
      tick();
      n_cmp++; if (bus.bubble_cnt !== 8'hFF || bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL sat_hold got cnt=%h v=%b want ff 0", bus.bubble_cnt, bus.ex_valid); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.id_ready !== 1'b0) begin n_err++; $display("FAIL sat_hazard_setup got v=%b rdy=%b want 1 0", bus.ex_valid, bus.id_ready); end
      rst = 1'b1;
      tick();
      n_cmp++; if (bus.bubble_cnt !== 8'h00 || bus.ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_hazard got cnt=%h v=%b want 00 0", bus.bubble_cnt, bus.ex_valid); end
      rst = 1'b0;
      set_idle();
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      set_idle();
      test_reset();
      test_single();
      test_stall();
      test_no_hazard();
      test_load_use();
      test_flush();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
